imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader for the `pipeline` core. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into instruction memory starting at address 0 and holds the core in reset until a verified image has been written. It drives the core's inputs, the opposite end from the retire/writeback debug outputs that the bench observes.

## Interface
- `DEPTH`, 1024: IMEM capacity in 32-bit words; upper bound on the frame word count.
- `ADDR_W`, 32: width of `o_imem_addr` (byte address).
- `i_clk`  in  1  clock, all state on rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_byte_valid`  in  1  source has a byte on `i_byte_data`.
- `i_byte_data`  in  8  stream byte.
- `o_byte_ready`  out  1  loader accepts a byte this cycle; a transfer occurs on an edge where valid&ready.
- `o_imem_we`  out  1  one-cycle IMEM write strobe.
- `o_imem_addr`  out  ADDR_W  byte address of the write, word-aligned.
- `o_imem_wdata`  out  32  assembled word.
- `o_core_rst`  out  1  active-high reset to `pipeline` (`i_rst`); high until load succeeds.
- `o_done`  out  1  image loaded and checksum verified (sticky).
- `o_err`  out  1  frame rejected (sticky).
- `o_words_loaded`  out  16  count of words written so far.

## Operation
- Frame: sync byte 0xA5, word count N as 16-bit little-endian (LEN_LO, LEN_HI), N×4 payload bytes, 1 checksum byte. The checksum is the XOR of all payload bytes only, so for N=0 it is 0x00.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: accepts bytes. 0xA5 moves the FSM to LEN_LO. Any other byte is discarded and the FSM stays in IDLE.
- LEN_LO: latches the low count byte. The FSM goes to LEN_HI.
- LEN_HI: latches the high count byte. If N > DEPTH the FSM goes to ERR. If N == 0 it goes to CSUM. Otherwise it goes to DATA.
- DATA:
  - Payload byte k of each word (k=0..3) goes into word bits [8k+7:8k]. Byte 0 is the LSB.
  - Every payload byte is XORed into the running checksum.
  - On acceptance of byte 3, a write is registered: `o_imem_wdata` = word, `o_imem_addr` = index×4, `o_imem_we`=1 for exactly the next cycle. The index and `o_words_loaded` then increment.
  - After the N-th word is accepted, the FSM goes to CSUM.
- CSUM: one byte is accepted. If it equals the running XOR, the FSM goes to DONE. Otherwise it goes to ERR.
- DONE and ERR are terminal until `i_rst_n`. In both, `o_byte_ready`=0 and incoming bytes are ignored.
- `o_core_rst` = (state != DONE). The core stays in reset in ERR.
- Word index and byte-lane counter are reset on every LEN_HI→DATA entry, so a partially written image from an earlier reset is overwritten from address 0.

## Timing
- Reset values (async, immediate):
  - state IDLE
  - `o_byte_ready`=1
  - `o_imem_we`=0, `o_imem_addr`=0, `o_imem_wdata`=0
  - `o_core_rst`=1
  - `o_done`=0, `o_err`=0
  - `o_words_loaded`=0
  - checksum 0x00
- Throughput: one byte per cycle. `o_byte_ready` stays 1 in IDLE through CSUM, including write-strobe cycles. No back-pressure is needed because writes are fire-and-forget.
- Write latency: 4th byte accepted at edge t, so `o_imem_we`=1 during cycle t→t+1. IMEM captures the word at edge t+1.
- Release:
  - The checksum byte is accepted at edge u. From edge u, `o_core_rst`=0 and `o_done`=1.
  - The earliest u is t+1, which equals the last write capture edge, so the core never fetches before the last word is stored.
- `o_err` rises at the edge that accepts the offending LEN_HI or checksum byte.
- `o_words_loaded` increments at the edge that ends the write strobe.
- Reset mid-frame: all state is abandoned immediately and `o_imem_we` is forced to 0. The next frame starts from IDLE.
- `i_byte_valid`=0 gaps of any length inside a frame are legal; the FSM simply waits.

## Test plan
- Sync hunt: send bytes 0x00, 0x5A, 0xA5, 01, 00, 13,00,00,00, 13 → one write of addr 0, data 0x00000013. Then `o_done`=1, `o_core_rst`=0, `o_words_loaded`=1.
- Multi-word image with random valid gaps: 27 words loading the ADDI/ADD/…/LHU program → writes at addr 0,4,…,104 with exact words. Release coincides with the capture edge of the last word. The core then runs and the bench reports all 27 checks PASSED.
- Bad checksum: A5, 01, 00, 11,22,33,44, 0x45 (expected 0x44) → one write occurs, then `o_err`=1, `o_done`=0, `o_core_rst` stays 1, `o_byte_ready`=0.
- Oversize count with DEPTH=16: A5, 11, 00 → `o_err`=1 at the LEN_HI edge, with no write strobe.
- Empty image: A5, 00, 00, 00 → no writes, then `o_done`=1 and `o_core_rst`=0. A variant with checksum byte 0x01 → `o_err`=1.
- Reset mid-load: assert `i_rst_n`=0 after the 2nd payload byte of word 3 → all outputs return to their reset values at once. A full reload then writes from addr 0 and ends in `o_done`=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Parses a framed byte stream (0xA5, N lo, N hi, N*4 payload bytes, XOR checksum),
// writes little-endian words to IMEM from address 0 and holds the core in reset
// until a frame with a matching checksum has been stored.
module imem_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_words_loaded
);

  localparam logic [16:0] DEPTH_MAX = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [15:0] len_in;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  lane;
  logic [23:0] partial;
  logic [7:0]  csum;

  // handshake and frame-length decode
  always_comb begin
    accept = i_byte_valid & o_byte_ready;
    len_in = {i_byte_data, len_lo};
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept && i_byte_data == 8'hA5) state_nxt = LEN_LO;
      LEN_LO: if (accept) state_nxt = LEN_HI;
      LEN_HI: if (accept) begin
        if ({1'b0, len_in} > DEPTH_MAX) state_nxt = ERR;
        else if (len_in == '0)          state_nxt = CSUM;
        else                            state_nxt = DATA;
      end
      DATA:   if (accept && lane == 2'd3 && (idx + 16'd1) == len) state_nxt = CSUM;
      CSUM:   if (accept) state_nxt = (i_byte_data == csum) ? DONE : ERR;
      DONE:   state_nxt = DONE;
      ERR:    state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs decoded from state; done/err are sticky because their states are terminal
  always_comb begin
    o_byte_ready = (state != DONE) && (state != ERR);
    o_core_rst   = (state != DONE);
    o_done       = (state == DONE);
    o_err        = (state == ERR);
  end

  // datapath: length capture, word assembly, checksum, write strobe and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_lo         <= '0;
      len            <= '0;
      idx            <= '0;
      lane           <= '0;
      partial        <= '0;
      csum           <= '0;
      o_imem_we      <= 1'b0;
      o_imem_addr    <= '0;
      o_imem_wdata   <= '0;
      o_words_loaded <= '0;
    end else begin
      o_imem_we <= 1'b0;
      // count a word when its strobe cycle ends, i.e. once IMEM has captured it
      if (o_imem_we) o_words_loaded <= o_words_loaded + 16'd1;
      if (accept) begin
        case (state)
          IDLE:   if (i_byte_data == 8'hA5) csum <= '0;
          LEN_LO: len_lo <= i_byte_data;
          LEN_HI: begin
            len  <= len_in;
            idx  <= '0;
            lane <= '0;
          end
          DATA: begin
            csum <= csum ^ i_byte_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: partial[7:0]   <= i_byte_data;
              2'd1: partial[15:8]  <= i_byte_data;
              2'd2: partial[23:16] <= i_byte_data;
              default: begin
                o_imem_we    <= 1'b1;
                o_imem_wdata <= {i_byte_data, partial};
                o_imem_addr  <= ADDR_W'({idx, 2'b00});
                idx          <= idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames checked cycle by cycle against a byte-position
// reference model, plus literal expectations for the directed frames.
module tb_imem_loader;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic [7:0]        data;
  logic              o_byte_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;
  logic              o_core_rst;
  logic              o_done;
  logic              o_err;
  logic [15:0]       o_words_loaded;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_byte_valid   (valid),
    .i_byte_data    (data),
    .o_byte_ready   (o_byte_ready),
    .o_imem_we      (o_imem_we),
    .o_imem_addr    (o_imem_addr),
    .o_imem_wdata   (o_imem_wdata),
    .o_core_rst     (o_core_rst),
    .o_done         (o_done),
    .o_err          (o_err),
    .o_words_loaded (o_words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame byte position arithmetic) ----------------
  // m_pos: -1 hunting for sync, otherwise index of the next byte after the sync byte
  // m_status: 0 loading, 1 loaded, 2 rejected
  int          m_pos;
  int          m_n;
  int          m_status;
  logic [7:0]  m_nlo;
  logic [7:0]  m_csum;
  logic [7:0]  m_pay [4];
  logic        m_we;
  logic [15:0] m_wl;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_pos = -1; m_n = 0; m_status = 0; m_nlo = '0; m_csum = '0;
    m_we = 1'b0; m_wl = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_step();
    int p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_we) m_wl = m_wl + 16'd1;
    m_we = 1'b0;
    if (valid && m_status == 0) begin
      if (m_pos < 0) begin
        if (data == 8'hA5) begin m_pos = 0; m_csum = '0; end
      end else if (m_pos == 0) begin
        m_nlo = data; m_pos = 1;
      end else if (m_pos == 1) begin
        m_n = int'({data, m_nlo});
        if (m_n > int'(DEPTH)) m_status = 2;
        else m_pos = 2;
      end else if (m_pos < 2 + 4 * m_n) begin
        p = m_pos - 2;
        m_pay[p % 4] = data;
        m_csum = m_csum ^ data;
        if (p % 4 == 3) begin
          m_we    = 1'b1;
          m_addr  = 32'((p / 4) * 4);
          m_wdata = {m_pay[3], m_pay[2], m_pay[1], m_pay[0]};
        end
        m_pos++;
      end else begin
        m_status = (data == m_csum) ? 1 : 2;
      end
    end
  endtask

  // per-cycle comparison of every output against the model
  initial begin
    logic [84:0] exp_v, act_v;
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #2;
      exp_v = {m_status == 0, m_we, m_status != 1, m_status == 1, m_status == 2,
               m_wl, m_addr, m_wdata};
      act_v = {o_byte_ready, o_imem_we, o_core_rst, o_done, o_err,
               o_words_loaded, o_imem_addr, o_imem_wdata};
      chk("cycle", act_v, exp_v);
    end
  end

  // IMEM stand-in: captures writes at the edge that ends each strobe
  logic [31:0] cap [DEPTH];
  int unsigned nwrites = 0;
  always @(posedge clk) begin
    if (o_imem_we) begin
      cap[int'(o_imem_addr >> 2)] <= o_imem_wdata;
      nwrites <= nwrites + 1;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] img [$];

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
    int unsigned gaps = $urandom_range(0, gap_max);
    for (int unsigned i = 0; i < gaps; i++) begin
      @(negedge clk); valid = 1'b0; data = 8'($urandom);
    end
    @(negedge clk); valid = 1'b1; data = b;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk); valid = 1'b0; data = '0;
    end
  endtask

  task automatic send_frame(input int unsigned n, input bit bad, input int unsigned gap_max);
    logic [15:0] nf = 16'(n);
    logic [7:0]  cs = '0;
    logic [31:0] w;
    logic [7:0]  b;
    send_byte(8'hA5, gap_max);
    send_byte(nf[7:0], gap_max);
    send_byte(nf[15:8], gap_max);
    if (n > DEPTH) return;
    for (int unsigned i = 0; i < n; i++) begin
      w = img[i];
      for (int unsigned k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        cs = cs ^ b;
        send_byte(b, gap_max);
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, gap_max);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; data = '0;
    #1;
    chk("rst_ready",   o_byte_ready,   1);
    chk("rst_we",      o_imem_we,      0);
    chk("rst_addr",    o_imem_addr,    0);
    chk("rst_wdata",   o_imem_wdata,   0);
    chk("rst_corerst", o_core_rst,     1);
    chk("rst_done",    o_done,         0);
    chk("rst_err",     o_err,          0);
    chk("rst_words",   o_words_loaded, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_status(input string tag, input bit done, input int unsigned writes,
                               input int unsigned base, input int unsigned words);
    chk({tag, "_done"},    o_done,          done);
    chk({tag, "_err"},     o_err,           !done);
    chk({tag, "_corerst"}, o_core_rst,      !done);
    chk({tag, "_ready"},   o_byte_ready,    0);
    chk({tag, "_writes"},  nwrites - base,  writes);
    chk({tag, "_words"},   o_words_loaded,  words);
  endtask

  logic [31:0] prog [27] = '{
    32'h00500093, 32'h00a00113, 32'h002081b3, 32'h40118233, 32'h0020f2b3,
    32'h0020e333, 32'h0020c3b3, 32'h00209433, 32'h0020d4b3, 32'h4020d533,
    32'h0020a5b3, 32'h0020b633, 32'h00f0f693, 32'h0ff0e713, 32'h0550c793,
    32'h00209813, 32'h0010d893, 32'h00000913, 32'h00312023, 32'h00412223,
    32'h00012983, 32'h00412a03, 32'h00510423, 32'h00811523, 32'h00814a83,
    32'h00a15b03, 32'h00415503
  };

  initial begin
    int unsigned base, n;
    bit bad;
    logic [7:0] junk;
    rst_n = 1'b0; valid = 1'b0; data = '0;
    do_reset();

    // sync hunt: junk before the sync byte is discarded
    img = '{32'h00000013};
    base = nwrites;
    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    send_frame(1, 1'b0, 0);
    idle(4);
    expect_status("hunt", 1'b1, 1, base, 1);
    chk("hunt_word0", cap[0], 32'h00000013);

    // 27-word program with random valid gaps
    do_reset();
    img = {};
    for (int i = 0; i < 27; i++) img.push_back(prog[i]);
    base = nwrites;
    send_frame(27, 1'b0, 3);
    idle(4);
    expect_status("prog", 1'b1, 27, base, 27);
    for (int i = 0; i < 27; i++) chk($sformatf("prog_w%0d", i), cap[i], prog[i]);

    // bad checksum: one write lands, frame rejected, trailing bytes ignored
    do_reset();
    img = '{32'h44332211};
    base = nwrites;
    send_frame(1, 1'b1, 0);
    send_byte(8'hA5, 0);
    idle(4);
    expect_status("badcs", 1'b0, 1, base, 1);
    chk("badcs_word0", cap[0], 32'h44332211);

    // oversize count, one past capacity
    do_reset();
    base = nwrites;
    send_frame(DEPTH + 1, 1'b0, 0);
    idle(4);
    expect_status("over", 1'b0, 0, base, 0);

    // empty image, good and bad checksum
    do_reset();
    base = nwrites;
    send_frame(0, 1'b0, 0);
    idle(3);
    expect_status("empty", 1'b1, 0, base, 0);
    do_reset();
    base = nwrites;
    send_frame(0, 1'b1, 0);
    idle(3);
    expect_status("empty_bad", 1'b0, 0, base, 0);

    // exactly full memory
    do_reset();
    img = {};
    for (int unsigned i = 0; i < DEPTH; i++) img.push_back($urandom);
    base = nwrites;
    send_frame(DEPTH, 1'b0, 1);
    idle(4);
    expect_status("full", 1'b1, DEPTH, base, DEPTH);
    chk("full_last", cap[DEPTH-1], img[DEPTH-1]);

    // reset after the 2nd payload byte of word 3, then a full reload
    do_reset();
    img = '{32'h11111111, 32'h22222222, 32'hCAFEF00D, 32'h0BADBEEF};
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
    for (int unsigned i = 0; i < 10; i++) begin
      logic [31:0] w = img[i / 4];
      send_byte(w[8*(i%4) +: 8], 0);
    end
    do_reset();
    base = nwrites;
    send_frame(4, 1'b0, 2);
    idle(4);
    expect_status("reload", 1'b1, 4, base, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("reload_w%0d", i), cap[i], img[i]);

    // randomized frames
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int unsigned j = 0; j < $urandom_range(0, 3); j++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, 1);
      end
      n   = $urandom_range(0, DEPTH + 2);
      bad = ($urandom_range(0, 3) == 0);
      img = {};
      for (int unsigned i = 0; i < n; i++) img.push_back($urandom);
      base = nwrites;
      send_frame(n, bad, 2);
      idle(4);
      if (n > DEPTH) expect_status("rnd", 1'b0, 0, base, 0);
      else begin
        expect_status("rnd", !bad, n, base, n);
        for (int unsigned i = 0; i < n; i++) chk("rnd_word", cap[i], img[i]);
      end
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
